// File: rtl/bcd_serial_addsub.sv
// ---------------------------------------------------------------------------
// bcd_serial_addsub
//
// Digit-serial unsigned BCD adder/subtractor. One BCD digit is processed per
// clock, least-significant digit first, through a single decimal-correction
// stage (binary add, then +6 when the digit sum exceeds 9).
//
// Optional feature macro: BCD_SUB_EN
//   defined   -> subtract mode via nines-complement of b, borrow-in = cin
//   undefined -> sub is ignored, every operation is an add, neg is tied to 0
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request; sampled only in IDLE
//   sub    in   0 = add, 1 = subtract (BCD_SUB_EN builds only)
//   a      in   [4*DIGITS-1:0] augend/minuend, packed BCD, digit 0 = [3:0]
//   b      in   [4*DIGITS-1:0] addend/subtrahend, packed BCD
//   cin    in   carry-in (add) / borrow-in (subtract)
//   busy   out  high whenever the FSM is not in IDLE
//   done   out  one-cycle pulse, result valid
//   sum    out  [4*DIGITS-1:0] packed BCD result
//   cout   out  decimal carry-out (add) / no-borrow flag (subtract)
//   neg    out  subtract result negative; sum holds the 10's complement
//   err    out  an operand digit was >9 when the operands were latched
//
// Handshake: start is a request accepted on any rising edge where the FSM is
// in IDLE (busy low); the accepting edge is E0. done is high for exactly one
// cycle DIGITS edges later, and sum/cout/neg/err are valid from that edge
// until the next accepted start. start while busy is dropped, not queued.
//
// The FSM state is held in state_q (type state_t) for hierarchical probing.
// ---------------------------------------------------------------------------
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               neg_q,   neg_d;
  logic               err_q,   err_d;

`ifdef BCD_SUB_EN
  logic               sub_q,   sub_d;
`else
  logic               unused_sub;
  assign unused_sub = sub;
`endif

  // Datapath for the digit currently selected by idx_q
  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] bd;
  logic [4:0] t;
  logic [3:0] sum_dig;
  logic       carry_nxt;
  logic       invalid_any;
  logic       last_dig;

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[i*4 +: 4];
        b_dig = b_q[i*4 +: 4];
      end
    end

`ifdef BCD_SUB_EN
    // Nines-complement of the subtrahend digit; wraps mod 16 for invalid digits
    bd = sub_q ? (4'd9 - b_dig) : b_dig;
`else
    bd = b_dig;
`endif

    t = {1'b0, a_dig} + {1'b0, bd} + {4'd0, carry_q};
    if (t > 5'd9) begin
      sum_dig   = t[3:0] + 4'd6;   // truncation to 4 bits is the decimal wrap
      carry_nxt = 1'b1;
    end else begin
      sum_dig   = t[3:0];
      carry_nxt = 1'b0;
    end

    invalid_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[i*4 +: 4] > 4'd9) || (b[i*4 +: 4] > 4'd9)) begin
        invalid_any = 1'b1;
      end
    end

    last_dig = (idx_q == IDX_W'(DIGITS - 1));
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
`ifdef BCD_SUB_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
`ifdef BCD_SUB_EN
          sub_d   = sub;
          carry_d = sub ? ~cin : cin;
`else
          carry_d = cin;
`endif
          sum_d   = '0;
          cout_d  = 1'b0;
          neg_d   = 1'b0;
          err_d   = invalid_any;
          state_d = CALC;
        end
      end

      CALC: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*4 +: 4] = sum_dig;
          end
        end
        carry_d = carry_nxt;
        if (last_dig) begin
          idx_d   = '0;
          cout_d  = carry_nxt;
`ifdef BCD_SUB_EN
          neg_d   = sub_q & ~carry_nxt;
`else
          neg_d   = 1'b0;
`endif
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
`ifdef BCD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Digit-serial, multi-digit unsigned BCD adder/subtractor with a start/done handshake. One BCD digit is processed per clock, least-significant digit first. A single decimal-correction stage (binary add, then +6 when the digit sum exceeds 9) is reused across all digits. It serves as the arithmetic core for multi-digit decimal datapaths such as counters, calculators and display accumulators, where a full-width combinational BCD chain is too large.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = add, 1 = subtract (requires BCD_SUB_EN)
- a  input  4*DIGITS  augend/minuend, packed BCD, digit 0 = bits [3:0]
- b  input  4*DIGITS  addend/subtrahend, packed BCD
- cin  input  1  carry-in (add) / borrow-in (subtract)
- busy  output  1  high when state ≠ IDLE
- done  output  1  one-cycle pulse; result valid
- sum  output  4*DIGITS  packed BCD result
- cout  output  1  decimal carry-out (add); no-borrow flag (subtract)
- neg  output  1  subtract only: result negative, sum holds 10's complement
- err  output  1  at least one operand digit was >9 when latched

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1: latch a, b and sub. Set digit index to 0. Set carry to cin for add, ~cin for subtract. Clear sum. Set err = OR over all digits of (digit > 9). Go to CALC.
- CALC, each cycle, for digit i:
  - bd = b[i] for add; bd = (9 − b[i]) mod 16 for subtract.
  - t = a[i] + bd + carry, 5-bit result.
  - If t > 9: sum[i] = (t + 6)[3:0] and carry = 1. Otherwise sum[i] = t[3:0] and carry = 0.
- After digit DIGITS−1: cout = final carry. neg = sub & ~final carry, 0 for add. Go to DONE.
- DONE: done = 1 for one cycle, then IDLE unconditionally.
- start while busy (CALC or DONE) is ignored and not queued.
- Invalid digits are still processed with the rule above. The result is deterministic but not meaningful; err flags it.
- sum, cout, neg and err hold their values until the next accepted start.

## Timing
- Reset (async, immediate) forces: state IDLE, busy 0, done 0, sum 0, cout 0, neg 0, err 0, index 0, carry 0.
- Reset asserted mid-CALC aborts the operation. The partial result is discarded and outputs return to their reset values.
- Edge E0 accepts start. CALC runs on edges E1..E_DIGITS. done is high from E_DIGITS to E_DIGITS+1.
- Latency is DIGITS cycles from the start edge to done.
- Minimum start-to-start interval is DIGITS+2 cycles.
- busy rises after E0 and falls after E_DIGITS+1.
- sum digit i updates on edge E_(i+1). Intermediate sum values are not valid before done.
- Inputs a, b, sub and cin may change freely after E0.

## Configuration
- BCD_SUB_EN defined: subtract mode as described; the nines-complement path is present.
- BCD_SUB_EN undefined:
  - sub input is ignored; every operation is an add.
  - neg is tied to 0.
  - The nines-complement logic is not compiled in.

## Test plan
- DIGITS=4, add, a=1234, b=5678, cin=0 → done 4 cycles after start; sum=6912, cout=0, neg=0, err=0.
- Add, a=9999, b=0000, cin=1 → sum=0000, cout=1. Also a=9999, b=9999, cin=1 → sum=9999, cout=1.
- BCD_SUB_EN, sub, a=5000, b=1234, cin=0 → sum=3766, cout=1, neg=0.
- BCD_SUB_EN, sub, a=1234, b=5000, cin=0 → sum=6234, cout=0, neg=1. Also a=0000, b=0000, cin=1 → sum=9999, neg=1.
- a=12A4 (digit 1 = 0xA), b=0001 → err=1 at done; sum matches the per-digit rule. Next valid operation clears err.
- Second start pulsed during CALC → ignored and only one done seen. Then rst_n pulsed low at E2 → busy=0, sum=0 immediately, and no done follows.
